imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time program loader upstream of the single-cycle core's instruction memory.
//  Accepts a byte stream over valid/ready: a 2-byte length header, then program words.
//  Packs each 4 bytes into a little-endian 32-bit word and writes it to instruction memory.
//  Holds the core in reset until the whole image is written, then releases it.
// PARAMETERS
//  ADDR_WIDTH  8  instruction-memory word-address width; depth = 2**ADDR_WIDTH words
// PORTS
//  clk          in   1           system clock, all state on rising edge
//  areset       in   1           asynchronous, active-low reset
//  rx_data      in   8           incoming byte
//  rx_valid     in   1           rx_data valid
//  rx_ready     out  1           loader can accept a byte this cycle
//  imem_we      out  1           instruction-memory write strobe, one cycle per word
//  imem_addr    out  ADDR_WIDTH  word address for the write
//  imem_wdata   out  32          assembled word
//  core_areset  out  1           active-low reset to the core; 0 = core held in reset
//  busy         out  1           load in progress (header or data phase)
//  done         out  1           image fully written, core released
//  err          out  1           header length exceeds memory depth
// BEHAVIOUR
//  - Handshake: a byte is accepted only on a cycle with rx_valid & rx_ready.
//    rx_data is ignored otherwise. rx_ready is a registered function of state.
//  - FSM states: LEN0, LEN1, DATA, WRITE, DONE, ERR. Reset state is LEN0.
//  - LEN0: rx_ready=1. The accepted byte becomes len[7:0]. Next state is LEN1.
//  - LEN1: rx_ready=1. The accepted byte becomes len[15:8].
//      If len==0, go to DONE.
//      Else if len > 2**ADDR_WIDTH, go to ERR.
//      Else clear word_idx and byte_cnt, and go to DATA.
//  - DATA: rx_ready=1. The accepted byte goes to word[8*byte_cnt +: 8], then byte_cnt++.
//      On the 4th accepted byte (byte_cnt==3), go to WRITE.
//  - WRITE: rx_ready=0; imem_we=1 for exactly this one cycle.
//      imem_addr = word_idx[ADDR_WIDTH-1:0]; imem_wdata = assembled word.
//      Then word_idx++ and byte_cnt=0.
//      If word_idx+1 == len, go to DONE; else go to DATA.
//  - Latency: imem_we is high in the cycle immediately after the 4th byte of a word is accepted.
//  - DONE: rx_ready=0, done=1, core_areset=1. Sticky until reset; further rx bytes are not accepted.
//  - ERR: rx_ready=0, err=1, core_areset=0. Sticky until reset; no memory writes.
//  - busy=1 in LEN0 (only after the first byte is accepted), LEN1, DATA and WRITE; 0 otherwise.
//  - core_areset=0 in every state except DONE. It is registered, so it deasserts glitch-free.
//  - Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_areset=0,
//    busy=0, done=0, err=0; len=0, word_idx=0, byte_cnt=0.
//  - Reset mid-operation: everything returns to LEN0 immediately (asynchronous).
//    The core is re-held in reset. Partially written memory is not cleared.
//  - Boundary len == 2**ADDR_WIDTH is legal: the last write is at address 2**ADDR_WIDTH-1.
//    word_idx is ADDR_WIDTH+1 bits wide so the compare does not wrap.
//  - rx_valid stalls inside a word are allowed; the partial word is held indefinitely.
//  - Byte order: the first data byte lands in bits [7:0], matching little-endian RV32 fetch.
// TESTING
//  1. Stream 02 00 13 05 10 00 93 05 20 00 ->
//     imem_we at addr 0 with 0x00100513, then at addr 1 with 0x00200593;
//     done=1 and core_areset=1 one cycle after the 2nd write.
//  2. Header 00 00 -> DONE directly, with no imem_we pulse and core_areset=1.
//  3. Header 01 01 (len=257, ADDR_WIDTH=8) -> err=1, rx_ready=0, core_areset=0,
//     and no writes for 20 further offered bytes.
//  4. Single-word load with rx_valid toggling 1/0 every cycle ->
//     exactly one imem_we, data intact, and rx_ready=0 in the WRITE cycle.
//  5. Assert areset after 2 of 4 data bytes ->
//     outputs go to reset values asynchronously; a fresh stream 01 00 AA BB CC DD
//     writes 0xDDCCBBAA to addr 0.
//  6. len=256, ADDR_WIDTH=8 -> 256 writes with addresses 0..255 in order,
//     the last at addr 0xFF, then done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs little-endian words into
// instruction memory and holds the core in reset until the whole image is written.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_areset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // 17 bits covers both the 16-bit header and a depth of up to 2**16 words
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t                r_state;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_word;
    logic                  r_rx_ready;
    logic                  r_imem_we;
    logic                  r_core_areset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic [ADDR_WIDTH:0]   w_idx_next;
    logic                  w_last_word;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_idx_next  = r_word_idx + 1'b1;
    assign w_last_word = (17'(w_idx_next) == {1'b0, r_len});

    // The assembled word and current index are stable through the WRITE cycle,
    // so they drive the memory port directly.
    assign imem_addr   = r_word_idx[ADDR_WIDTH-1:0];
    assign imem_wdata  = r_word;
    assign rx_ready    = r_rx_ready;
    assign imem_we     = r_imem_we;
    assign core_areset = r_core_areset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state       <= LEN0;
            r_len         <= '0;
            r_word_idx    <= '0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_rx_ready    <= 1'b1;
            r_imem_we     <= 1'b0;
            r_core_areset <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_busy     <= 1'b1;
                        r_state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (w_len_full == 16'd0) begin
                            r_state       <= DONE;
                            r_rx_ready    <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_core_areset <= 1'b1;
                        end else if ({1'b0, w_len_full} > DEPTH) begin
                            r_state    <= ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_word_idx <= '0;
                            r_byte_cnt <= '0;
                            r_state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state    <= WRITE;
                            r_rx_ready <= 1'b0;
                            r_imem_we  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_imem_we  <= 1'b0;
                    r_word_idx <= w_idx_next;
                    r_byte_cnt <= '0;
                    if (w_last_word) begin
                        r_state       <= DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_core_areset <= 1'b1;
                    end else begin
                        r_state    <= DATA;
                        r_rx_ready <= 1'b1;
                    end
                end
                DONE, ERR: ;
                default: r_state <= LEN0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader: a driver streams images while a
// monitor pops expected (addr, word) pairs whenever a memory write strobe appears.
module tb_imem_boot_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready, imem_we, core_areset, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .areset(areset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_areset(core_areset), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int gap_mode = 0;   // 0: back-to-back, 1: valid toggles, 2: random idle gaps
    logic [AW+31:0] exp_q[$];
    logic [7:0]     stim [0:4*DEPTH-1];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (areset && imem_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%h", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write addr/data actual=%0h/%h required=%0h/%h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
            chk("write_cycle_ready_busy_core", {rx_ready, busy, core_areset}, 3'b010);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Entered and left at a negedge; rx_ready sampled here is what the next posedge sees.
    task automatic send(input logic [7:0] b);
        logic acc = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = rx_ready;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!acc) chk("send_timeout", 0, 1);
        if (gap_mode == 1) @(negedge clk);
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 areset = 1'b0;
        #1;
        chk("reset_outputs",
            {rx_ready, imem_we, core_areset, busy, done, err, imem_addr, imem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0});
        exp_q.delete();
        @(negedge clk);
        areset = 1'b1;
    endtask

    // Reference: header then len words; word i is stim[4i..4i+3], first byte in the LSBs.
    task automatic run_load(input int len);
        int base = wr_cnt;
        bit ok = (len != 0) && (len <= DEPTH);
        if (ok)
            for (int i = 0; i < len; i++)
                exp_q.push_back({8'(i), stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]});
        send(8'(len));
        chk("busy_after_first_byte", busy, 1);
        send(8'(len >> 8));
        if (ok) begin
            for (int i = 0; i < 4*len; i++) send(stim[i]);
            if (gap_mode == 0) begin
                chk("last_write_then_done0", {imem_we, done}, 2'b10);
                @(negedge clk);
                chk("done_one_cycle_after_write", {done, core_areset}, 2'b11);
            end
        end else if (len > DEPTH) begin
            @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                if (i % 5 == 0) chk("err_rx_ready_low", rx_ready, 0);
                @(negedge clk);
            end
            rx_valid = 1'b0;
        end
        for (int t = 0; t < 10 && !(done || err); t++) @(negedge clk);
        chk("final_done_err", {done, err}, (len > DEPTH) ? 2'b01 : 2'b10);
        chk("final_core_areset", core_areset, (len > DEPTH) ? 0 : 1);
        chk("final_ready_busy", {rx_ready, busy}, 2'b00);
        chk("write_count", wr_cnt - base, ok ? len : 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_state",
            {rx_ready, imem_we, core_areset, busy, done, err, imem_addr, imem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0});
        areset = 1'b1;
        @(negedge clk);

        // Two-word RV32 image
        gap_mode = 0;
        {stim[0], stim[1], stim[2], stim[3]} = {8'h13, 8'h05, 8'h10, 8'h00};
        {stim[4], stim[5], stim[6], stim[7]} = {8'h93, 8'h05, 8'h20, 8'h00};
        run_load(2);
        do_reset();

        // Empty image
        run_load(0);
        do_reset();

        // Oversized header, then a random oversized one
        run_load(257);
        do_reset();
        run_load(300 + $urandom_range(0, 1000));
        do_reset();

        // Single word with valid toggling
        gap_mode = 1;
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        run_load(1);
        do_reset();

        // Reset in the middle of a word, then a fresh image
        gap_mode = 0;
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        do_reset();
        {stim[0], stim[1], stim[2], stim[3]} = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_q.push_back({8'h00, 32'hDDCCBBAA});
        send(8'h01); send(8'h00);
        for (int i = 0; i < 4; i++) send(stim[i]);
        for (int t = 0; t < 10 && !done; t++) @(negedge clk);
        chk("fresh_after_reset_done", {done, core_areset}, 2'b11);
        chk("fresh_after_reset_drained", exp_q.size(), 0);
        do_reset();

        // Random short images with random gaps
        gap_mode = 2;
        repeat (4) begin
            int n = $urandom_range(1, 9);
            for (int i = 0; i < 4*n; i++) stim[i] = 8'($urandom);
            run_load(n);
            do_reset();
        end

        // Full depth
        for (int i = 0; i < 4*DEPTH; i++) stim[i] = 8'($urandom);
        run_load(DEPTH);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
